// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler_if
// Purpose  : Requester handshakes and transmitter control bundle for
//            uart_tx_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_scheduler_if;
    logic       req0_valid_i;
    logic [7:0] req0_data_i;
    logic       req0_ready_o;
    logic       req1_valid_i;
    logic [7:0] req1_data_i;
    logic       req1_ready_o;
    logic       tx_en_o;
    logic       tx_start_o;
    logic [4:0] tx_conf_o;
    logic [7:0] tx_data_o;
    logic       tx_done_i;

    modport master (
        input  req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, tx_done_i,
        output req0_ready_o, req1_ready_o, tx_en_o, tx_start_o, tx_conf_o, tx_data_o
    );

    modport slave (
        output req0_valid_i, req0_data_i, req1_valid_i, req1_data_i, tx_done_i,
        input  req0_ready_o, req1_ready_o, tx_en_o, tx_start_o, tx_conf_o, tx_data_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_scheduler
// Purpose  : Round-robin scheduler feeding two byte requesters into one UART
//            transmitter; optional frame watchdog via UART_TX_SCHED_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_scheduler #(
    parameter int TIMEOUT_W      = 20,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [4:0]          conf_i,
    uart_tx_scheduler_if.master bus,
    output logic                busy_o,
    output logic                grant_o,
    output logic                timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       ptr_q, ptr_d;
    logic       grant_q, grant_d;
    logic       start_q, start_d;
    logic [7:0] data_q, data_d;
    logic [4:0] conf_q, conf_d;

    logic       any_valid;
    logic       sel;
    logic       accept;
    logic       expire;

    if (TIMEOUT_CYCLES < 1 || longint'(TIMEOUT_CYCLES) >= (longint'(1) << TIMEOUT_W)) begin : g_bad_timeout_cfg
        $error("TIMEOUT_CYCLES does not fit in TIMEOUT_W bits");
    end

    // A lone valid always wins; the pointer only breaks ties.
    assign any_valid        = bus.req0_valid_i | bus.req1_valid_i;
    assign sel              = (bus.req0_valid_i & bus.req1_valid_i) ? ptr_q : bus.req1_valid_i;
    assign accept           = (state_q == IDLE) & enable_i & any_valid;
    assign bus.req0_ready_o = accept & ~sel;
    assign bus.req1_ready_o = accept & sel;

    assign busy_o         = (state_q != IDLE);
    assign grant_o        = grant_q;
    assign bus.tx_start_o = start_q;
    assign bus.tx_data_o  = data_q;
    assign bus.tx_conf_o  = conf_q;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] C_TO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    // A done pulse on the final count wins over the watchdog.
    assign expire = (state_q == WAIT) & ~bus.tx_done_i & (cnt_q == C_TO_LAST);

    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = expire;
        if (state_q == START) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o   = timeout_q;
    assign bus.tx_en_o = (enable_i | busy_o) & ~timeout_q;
`else
    assign expire      = 1'b0;
    assign timeout_o   = 1'b0;
    assign bus.tx_en_o = enable_i | busy_o;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        conf_d  = conf_q;
        start_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = START;
                    start_d = 1'b1;
                    data_d  = sel ? bus.req1_data_i : bus.req0_data_i;
                    conf_d  = conf_i;
                    grant_d = sel;
                    ptr_d   = ~sel;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (bus.tx_done_i || expire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            grant_q <= 1'b0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            conf_q  <= 5'b00000;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            start_q <= start_d;
            data_q  <= data_d;
            conf_q  <= conf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_scheduler
// Purpose  : Directed scoreboard bench for uart_tx_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_scheduler;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [4:0] conf;
    logic       busy;
    logic       grant;
    logic       timeout;

    int         checks = 0;
    int         errors = 0;
    logic       to_expect = 1'b0;
    logic       all_busy;
    logic [13:0] exp_q[$];
    logic [13:0] e;

    uart_tx_scheduler_if bus_if ();

    uart_tx_scheduler #(
        .TIMEOUT_W      (20),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .enable_i  (enable),
        .conf_i    (conf),
        .bus       (bus_if),
        .busy_o    (busy),
        .grant_o   (grant),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pulse_done();
        bus_if.tx_done_i = 1'b1;
        tick();
        bus_if.tx_done_i = 1'b0;
    endtask

    // Scoreboard monitor: every start strobe must match the next expected frame.
    always @(negedge clk) begin
        if (!rst && bus_if.tx_start_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_start: got data 0x%0h expected no frame", bus_if.tx_data_o);
            end else begin
                e = exp_q.pop_front();
                if ({grant, bus_if.tx_conf_o, bus_if.tx_data_o} !== e) begin
                    errors++;
                    $display("FAIL frame: got grant=%0b conf=%05b data=0x%0h expected grant=%0b conf=%05b data=0x%0h",
                             grant, bus_if.tx_conf_o, bus_if.tx_data_o, e[13], e[12:8], e[7:0]);
                end
            end
        end
        if (timeout && !to_expect) begin
            errors++;
            $display("FAIL spurious_timeout: got timeout_o=1 expected 0");
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got time limit expired expected $finish");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1; enable = 1'b0; conf = 5'b0;
        bus_if.req0_valid_i = 1'b0; bus_if.req0_data_i = 8'h00;
        bus_if.req1_valid_i = 1'b0; bus_if.req1_data_i = 8'h00;
        bus_if.tx_done_i    = 1'b0;
        repeat (3) tick();

        chk("rst_busy",    busy, 0);
        chk("rst_grant",   grant, 0);
        chk("rst_data",    bus_if.tx_data_o, 0);
        chk("rst_conf",    bus_if.tx_conf_o, 0);
        chk("rst_start",   bus_if.tx_start_o, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_tx_en",   bus_if.tx_en_o, 0);

        // Basic single frame from req0
        rst = 1'b0;
        tick();
        enable = 1'b1; conf = 5'b11011;
        bus_if.req0_data_i = 8'hA5; bus_if.req0_valid_i = 1'b1;
        #1;
        chk("ready0_accept", bus_if.req0_ready_o, 1);
        chk("ready1_idle",   bus_if.req1_ready_o, 0);
        chk("tx_en_enabled", bus_if.tx_en_o, 1);
        exp_q.push_back({1'b0, 5'b11011, 8'hA5});
        tick();
        chk("start_strobe", bus_if.tx_start_o, 1);
        chk("busy_start",   busy, 1);
        chk("ready0_start_blocked", bus_if.req0_ready_o, 0);
        tick();
        chk("start_one_cycle", bus_if.tx_start_o, 0);
        chk("ready0_wait_blocked", bus_if.req0_ready_o, 0);
        bus_if.req0_valid_i = 1'b0;
        repeat (4) tick();
        pulse_done();
        chk("busy_after_done", busy, 0);
        chk("data_stable", bus_if.tx_data_o, 8'hA5);

        // Done ignored in IDLE and START
        pulse_done();
        chk("idle_done_ignored", busy, 0);
        conf = 5'b00100;
        bus_if.req1_data_i = 8'h5A; bus_if.req1_valid_i = 1'b1;
        #1;
        chk("ready1_accept", bus_if.req1_ready_o, 1);
        exp_q.push_back({1'b1, 5'b00100, 8'h5A});
        tick();
        bus_if.req1_valid_i = 1'b0;
        pulse_done();
        chk("start_done_ignored", busy, 1);
        chk("grant_req1", grant, 1);
        repeat (2) tick();
        pulse_done();
        chk("busy_after_done2", busy, 0);

        // Both valid continuously: alternation
        conf = 5'b01010;
        bus_if.req0_data_i = 8'h11; bus_if.req1_data_i = 8'h22;
        exp_q.push_back({1'b0, 5'b01010, 8'h11});
        exp_q.push_back({1'b1, 5'b01010, 8'h22});
        exp_q.push_back({1'b0, 5'b01010, 8'h11});
        exp_q.push_back({1'b1, 5'b01010, 8'h22});
        bus_if.req0_valid_i = 1'b1; bus_if.req1_valid_i = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_ready", {bus_if.req1_ready_o, bus_if.req0_ready_o}, (k % 2 == 1) ? 2'b10 : 2'b01);
            tick();
            if (k == 3) begin
                bus_if.req0_valid_i = 1'b0; bus_if.req1_valid_i = 1'b0;
            end
            tick();
            repeat (9) tick();
            pulse_done();
        end

        // Pointer=1 tie goes to req1, enable drop mid-frame
        bus_if.req0_data_i = 8'h33; bus_if.req0_valid_i = 1'b1;
        #1;
        exp_q.push_back({1'b0, 5'b01010, 8'h33});
        tick();
        bus_if.req0_valid_i = 1'b0;
        tick();
        pulse_done();
        bus_if.req0_data_i = 8'h44; bus_if.req1_data_i = 8'h55;
        bus_if.req0_valid_i = 1'b1; bus_if.req1_valid_i = 1'b1;
        #1;
        chk("rr_ptr1_req1_first", {bus_if.req1_ready_o, bus_if.req0_ready_o}, 2'b10);
        exp_q.push_back({1'b1, 5'b01010, 8'h55});
        tick();
        tick();
        repeat (3) tick();
        enable = 1'b0;
        #1;
        chk("disable_ready_low", {bus_if.req1_ready_o, bus_if.req0_ready_o}, 2'b00);
        chk("disable_tx_en_busy", bus_if.tx_en_o, 1);
        repeat (2) tick();
        chk("frame_survives_disable", busy, 1);
        pulse_done();
        chk("disable_idle_busy", busy, 0);
        chk("disable_idle_tx_en", bus_if.tx_en_o, 0);
        repeat (3) tick();
        chk("disable_no_ready", {bus_if.req1_ready_o, bus_if.req0_ready_o}, 2'b00);
        chk("disable_data_stable", bus_if.tx_data_o, 8'h55);
        enable = 1'b1;
        #1;
        chk("rr_req0_next", {bus_if.req1_ready_o, bus_if.req0_ready_o}, 2'b01);
        exp_q.push_back({1'b0, 5'b01010, 8'h44});
        tick();
        bus_if.req0_valid_i = 1'b0; bus_if.req1_valid_i = 1'b0;
        tick();
        pulse_done();

        // Hung frame
        conf = 5'b00000;
        bus_if.req0_data_i = 8'h3C; bus_if.req0_valid_i = 1'b1;
        #1;
        exp_q.push_back({1'b0, 5'b00000, 8'h3C});
        tick();
        bus_if.req0_valid_i = 1'b0;
        tick();
`ifdef UART_TX_SCHED_TIMEOUT_EN
        repeat (15) tick();
        chk("wait_before_timeout", busy, 1);
        chk("no_early_timeout", timeout, 0);
        to_expect = 1'b1;
        tick();
        chk("timeout_pulse", timeout, 1);
        chk("timeout_tx_en_low", bus_if.tx_en_o, 0);
        chk("timeout_idle", busy, 0);
        tick();
        to_expect = 1'b0;
        chk("timeout_one_cycle", timeout, 0);
        chk("tx_en_after_timeout", bus_if.tx_en_o, 1);
`else
        all_busy = 1'b1;
        repeat (1000) begin
            tick();
            if (!busy) all_busy = 1'b0;
        end
        chk("wait_held_1000", all_busy, 1);
        pulse_done();
        chk("busy_after_long_wait", busy, 0);
`endif

        // Reset mid-WAIT
        conf = 5'b10101;
        bus_if.req0_data_i = 8'h77; bus_if.req0_valid_i = 1'b1;
        #1;
        exp_q.push_back({1'b0, 5'b10101, 8'h77});
        tick();
        bus_if.req0_valid_i = 1'b0;
        tick();
        repeat (5) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy",    busy, 0);
        chk("midrst_start",   bus_if.tx_start_o, 0);
        chk("midrst_data",    bus_if.tx_data_o, 0);
        chk("midrst_conf",    bus_if.tx_conf_o, 0);
        chk("midrst_grant",   grant, 0);
        chk("midrst_timeout", timeout, 0);
        chk("midrst_tx_en",   bus_if.tx_en_o, 1);
        repeat (20) tick();
        rst = 1'b0;
        tick();

        // Pointer returns to req0 after reset
        bus_if.req0_data_i = 8'h88; bus_if.req1_data_i = 8'h99;
        bus_if.req0_valid_i = 1'b1; bus_if.req1_valid_i = 1'b1;
        #1;
        chk("ptr_reset_req0", {bus_if.req1_ready_o, bus_if.req0_ready_o}, 2'b01);
        exp_q.push_back({1'b0, 5'b10101, 8'h88});
        tick();
        bus_if.req0_valid_i = 1'b0; bus_if.req1_valid_i = 1'b0;
        tick();
        pulse_done();
        tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 Parameter TIMEOUT_W, default 20: width of the frame-timeout counter.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: cycles in WAIT before a frame is declared hung; SHALL fit in TIMEOUT_W bits.
REQ-003 clk_i  input  1  sole clock; all state on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 enable_i  input  1  scheduler enable; low blocks new acceptances.
REQ-006 conf_i  input  5  frame config {data_size[1:0], stop_size[1:0], parity_en}, sampled at acceptance.
REQ-007 req0_valid_i / req1_valid_i  input  1  requester has a byte.
REQ-008 req0_data_i / req1_data_i  input  8  requester byte.
REQ-009 req0_ready_o / req1_ready_o  output  1  scheduler accepts the byte this cycle.
REQ-010 tx_en_o  output  1  transmitter enable.
REQ-011 tx_start_o  output  1  one-cycle frame start strobe to transmitter.
REQ-012 tx_conf_o  output  5  latched frame config to transmitter.
REQ-013 tx_data_o  output  8  latched byte to transmitter.
REQ-014 tx_done_i  input  1  transmitter frame-complete pulse.
REQ-015 busy_o  output  1  high in any state other than IDLE.
REQ-016 grant_o  output  1  index of requester owning the current or last frame.
REQ-017 timeout_o  output  1  one-cycle pulse on frame timeout.

Function
REQ-018 FSM states SHALL be IDLE, START, WAIT.
REQ-019 IDLE: when enable_i=1 and any valid is high, exactly one ready_o SHALL be driven high combinationally, chosen by round-robin.
REQ-020 Round-robin: priority pointer favours the requester not served last; one valid alone always wins; pointer resets to req0.
REQ-021 On valid&ready: data -> tx_data_o, conf_i -> tx_conf_o, grant_o updated, pointer flipped, IDLE -> START on the next edge.
REQ-022 START lasts exactly one cycle with tx_start_o=1; START -> WAIT unconditionally.
REQ-023 WAIT: on tx_done_i=1, WAIT -> IDLE; a new acceptance is possible in the first IDLE cycle (minimum two idle-free cycles between start strobes plus frame time).
REQ-024 Latency: acceptance cycle N -> tx_start_o high in cycle N+1.
REQ-025 tx_done_i SHALL be ignored in IDLE and START.
REQ-026 ready_o SHALL be 0 in START and WAIT and whenever enable_i=0.
REQ-027 tx_data_o and tx_conf_o SHALL be stable from acceptance until the next acceptance.
REQ-028 tx_en_o SHALL equal enable_i OR busy_o, except as in REQ-033.
REQ-029 enable_i falling mid-frame SHALL NOT abort the frame; the frame completes, then no new acceptances.
REQ-030 Both valids high with pointer=1: req1 served first, req0 next frame.

Reset
REQ-031 rst_i=1 SHALL immediately force state IDLE, pointer=0, grant_o=0, tx_data_o=0, tx_conf_o=0, tx_start_o=0, timeout_o=0, busy_o=0, timeout counter=0; ready_o/tx_en_o follow from these. Reset mid-frame abandons the frame without a timeout pulse.

Configuration
REQ-032 Macro UART_TX_SCHED_TIMEOUT_EN SHALL compile in the frame watchdog.
REQ-033 With it: counter clears on entry to WAIT, increments each WAIT cycle; at count TIMEOUT_CYCLES-1 without tx_done_i, state -> IDLE, timeout_o=1 and tx_en_o=0 for that one cycle; tx_done_i in the same cycle takes precedence (no timeout).
REQ-034 Without it: no counter logic; timeout_o tied 0; WAIT held until tx_done_i.

Verification
REQ-035 Reset release, enable_i=1, req0 valid data 0xA5 conf 5'b11011 -> req0_ready_o 1 cycle, next cycle tx_start_o=1, tx_data_o=0xA5, tx_conf_o=5'b11011, grant_o=0.
REQ-036 Both valid continuously (req0 0x11, req1 0x22), done after 10 cycles each -> frame order 0x11, 0x22, 0x11, 0x22.
REQ-037 tx_done_i pulsed in START and in IDLE -> no state change; done in WAIT -> busy_o low next cycle.
REQ-038 enable_i dropped 3 cycles into WAIT, both valid -> frame completes on done, no further ready_o, tx_en_o low after return to IDLE.
REQ-039 Macro defined, TIMEOUT_CYCLES=16, no done -> timeout_o pulse 16 cycles after WAIT entry, tx_en_o low that cycle, busy_o low after; macro undefined -> busy_o held for 1000 cycles.
REQ-040 rst_i asserted mid-WAIT -> all outputs at reset values in the same cycle, no timeout_o pulse.
